// File: rtl/kalman_pkg.sv
// Shared types and constants for the sequential 2x2 Kalman covariance-update unit.
package kalman_pkg;

  typedef enum logic [1:0] {
    MODE_ABS  = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_WRAP = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Element index n: bit 1 selects the gain row (K0/K1), bit 0 selects the P row-0 column.
  localparam logic [1:0] ELEM_00 = 2'd0;
  localparam logic [1:0] ELEM_01 = 2'd1;
  localparam logic [1:0] ELEM_10 = 2'd2;
  localparam logic [1:0] ELEM_11 = 2'd3;
  localparam int         NUM_ELEMS = 4;

endpackage

// File: rtl/kalman_p_mulsub.sv
// Combinational element datapath: t = sat((p_row0 * k) >> K_FRAC), then pe - t under the
// selected result policy, plus the t > pe underflow flag.
module kalman_p_mulsub
  import kalman_pkg::*;
#(
  parameter int P_WIDTH = 23,
  parameter int K_WIDTH = 13,
  parameter int K_FRAC  = 13
) (
  input  logic [P_WIDTH-1:0] pe,
  input  logic [P_WIDTH-1:0] p_row0,
  input  logic [K_WIDTH-1:0] k,
  input  logic [1:0]         mode,
  output logic [P_WIDTH-1:0] result,
  output logic               underflow
);

  localparam int PROD_W = P_WIDTH + K_WIDTH;

  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  shifted;
  logic [P_WIDTH-1:0] t;

  always_comb begin
    prod      = PROD_W'(p_row0) * PROD_W'(k);
    shifted   = prod >> K_FRAC;
    // Any bit above P_WIDTH means t no longer fits an element: clamp to all-ones.
    t         = (|shifted[PROD_W-1:P_WIDTH]) ? '1 : shifted[P_WIDTH-1:0];
    underflow = (t > pe);
    case (mode)
      MODE_SAT:  result = underflow ? '0 : (pe - t);
      MODE_WRAP: result = pe - t;
      default:   result = underflow ? (t - pe) : (pe - t);
    endcase
  end

endmodule

// File: rtl/kalman_p_update_seq.sv
// Sequential 2x2 covariance update P_new[i][j] = P[i][j] - K[i]*P[0][j], one element per
// clock through a single shared multiplier.
module kalman_p_update_seq
  import kalman_pkg::*;
#(
  parameter int P_WIDTH = 23,
  parameter int K_WIDTH = 13,
  parameter int K_FRAC  = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [P_WIDTH-1:0] p00_in,
  input  logic [P_WIDTH-1:0] p01_in,
  input  logic [P_WIDTH-1:0] p10_in,
  input  logic [P_WIDTH-1:0] p11_in,
  input  logic [K_WIDTH-1:0] k0_in,
  input  logic [K_WIDTH-1:0] k1_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] p00_out,
  output logic [P_WIDTH-1:0] p01_out,
  output logic [P_WIDTH-1:0] p10_out,
  output logic [P_WIDTH-1:0] p11_out,
  output logic [3:0]         underflow,
  output logic               busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and stays high with
  // stable data until out_ready is seen. Neither side's valid depends on the other's ready.

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         mode_q, mode_d;
  logic [P_WIDTH-1:0] p_cap_q [NUM_ELEMS];
  logic [P_WIDTH-1:0] p_cap_d [NUM_ELEMS];
  logic [K_WIDTH-1:0] k0_q, k0_d, k1_q, k1_d;
  logic [P_WIDTH-1:0] res_q [NUM_ELEMS];
  logic [P_WIDTH-1:0] res_d [NUM_ELEMS];
  logic [3:0]         uflow_q, uflow_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [P_WIDTH-1:0] mul_pe, mul_row0, mul_res;
  logic [K_WIDTH-1:0] mul_k;
  logic               mul_uf;

  always_comb begin
    mul_pe   = p_cap_q[idx_q];
    mul_row0 = idx_q[0] ? p_cap_q[ELEM_01] : p_cap_q[ELEM_00];
    mul_k    = idx_q[1] ? k1_q : k0_q;
  end

  kalman_p_mulsub #(
    .P_WIDTH (P_WIDTH),
    .K_WIDTH (K_WIDTH),
    .K_FRAC  (K_FRAC)
  ) u_mulsub (
    .pe        (mul_pe),
    .p_row0    (mul_row0),
    .k         (mul_k),
    .mode      (mode_q),
    .result    (mul_res),
    .underflow (mul_uf)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    p_cap_d = p_cap_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    res_d   = res_q;
    uflow_d = uflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          p_cap_d[ELEM_00] = p00_in;
          p_cap_d[ELEM_01] = p01_in;
          p_cap_d[ELEM_10] = p10_in;
          p_cap_d[ELEM_11] = p11_in;
          k0_d    = k0_in;
          k1_d    = k1_in;
          mode_d  = mode;
          idx_d   = ELEM_00;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d[idx_q]   = mul_res;
        uflow_d[idx_q] = mul_uf;
        idx_d          = idx_q + 2'd1;
        if (idx_q == ELEM_11) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with it.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= ELEM_00;
      mode_q      <= 2'd0;
      k0_q        <= '0;
      k1_q        <= '0;
      uflow_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int n = 0; n < NUM_ELEMS; n++) begin
        p_cap_q[n] <= '0;
        res_q[n]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      uflow_q     <= uflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int n = 0; n < NUM_ELEMS; n++) begin
        p_cap_q[n] <= p_cap_d[n];
        res_q[n]   <= res_d[n];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p00_out   = res_q[ELEM_00];
  assign p01_out   = res_q[ELEM_01];
  assign p10_out   = res_q[ELEM_10];
  assign p11_out   = res_q[ELEM_11];
  assign underflow = uflow_q;

endmodule
